// File: rtl/bsg_one_fifo_rr_arb.sv
// bsg_one_fifo_rr_arb
//   Round-robin arbiter feeding a single-entry buffer shared by els_p
//   ready/valid producers. A producer that sends a beat without last_i
//   keeps the grant until it sends its final beat, so packets from
//   different producers are never interleaved on the output.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   reset_i  : asynchronous active-high reset
//   v_i      : per-requester valid            [els_p]
//   data_i   : per-requester beat, lane k at [k*width_p +: width_p]
//   last_i   : per-requester final-beat flag  [els_p]
//   ready_o  : per-requester accept, one-hot or zero
//   v_o      : buffer holds a beat
//   data_o   : buffered beat
//   tag_o    : index of the requester that supplied the buffered beat
//   last_o   : buffered beat's last flag
//   yumi_i   : consumer takes the buffered beat (only legal with v_o=1)

module bsg_one_fifo_rr_arb #(
    parameter  int els_p     = 4,
    parameter  int width_p   = 16,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    input  logic [els_p-1:0]           last_i,
    output logic [els_p-1:0]           ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [lg_els_lp-1:0]       tag_o,
    output logic                       last_o,
    input  logic                       yumi_i
);

    logic                   full_r;
    logic [width_p-1:0]     data_r;
    logic [lg_els_lp-1:0]   tag_r;
    logic                   last_r;
    logic [lg_els_lp-1:0]   ptr_r;
    logic                   lock_r;
    logic [lg_els_lp-1:0]   lock_idx_r;

    logic [width_p-1:0]     data_arr [els_p];
    logic                   grant_v;
    logic [lg_els_lp-1:0]   grant_idx;
    logic [lg_els_lp-1:0]   cand;
    logic                   enq;

    // (base + off) mod els_p without a divider; off is always < els_p so a
    // single conditional subtract is enough, and the result never reaches
    // els_p even when els_p is not a power of two.
    function automatic logic [lg_els_lp-1:0] wrap_inc(
        input logic [lg_els_lp-1:0] base,
        input int                   off
    );
        logic [lg_els_lp:0] sum;
        sum = {1'b0, base} + (lg_els_lp+1)'(off);
        if (sum >= (lg_els_lp+1)'(els_p)) begin
            sum = sum - (lg_els_lp+1)'(els_p);
        end
        return sum[lg_els_lp-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < els_p; gi++) begin : g_unpack
            assign data_arr[gi] = data_i[gi*width_p +: width_p];
        end
    endgenerate

    // Arbitration. The scan runs from the farthest offset down to offset 0
    // so the requester closest to ptr_r is the last (winning) assignment.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (lock_r) begin
            grant_v   = v_i[lock_idx_r];
            grant_idx = lock_idx_r;
        end else begin
            for (int i = els_p - 1; i >= 0; i--) begin
                cand = wrap_inc(ptr_r, i);
                if (v_i[cand]) begin
                    grant_v   = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign enq = grant_v & ~full_r;

    // reset_i gates ready_o directly so producers see no accept while reset
    // is held, even though the flops are already cleared.
    generate
        for (genvar gi = 0; gi < els_p; gi++) begin : g_ready
            assign ready_o[gi] = ~reset_i & enq & (grant_idx == lg_els_lp'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_r     <= 1'b0;
            data_r     <= '0;
            tag_r      <= '0;
            last_r     <= 1'b0;
            ptr_r      <= '0;
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
        end else begin
            if (enq) begin
                full_r <= 1'b1;
                data_r <= data_arr[grant_idx];
                tag_r  <= grant_idx;
                last_r <= last_i[grant_idx];
                if (last_i[grant_idx]) begin
                    lock_r <= 1'b0;
                    ptr_r  <= wrap_inc(grant_idx, 1);
                end else begin
                    lock_r     <= 1'b1;
                    lock_idx_r <= grant_idx;
                end
            end else if (yumi_i && full_r) begin
                // Enqueue is impossible while full, so no bypass case exists.
                full_r <= 1'b0;
            end
        end
    end

    assign v_o    = full_r;
    assign data_o = data_r;
    assign last_o = last_r;

    generate
        if (els_p == 1) begin : g_tag_single
            assign tag_o = '0;
        end else begin : g_tag_multi
            assign tag_o = tag_r;
        end
    endgenerate

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> full_r);

endmodule

// File: tb/tb_bsg_one_fifo_rr_arb.sv
module tb_bsg_one_fifo_rr_arb;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic [N-1:0]     v_i, last_i, ready_o;
    logic [N*W-1:0]   data_i;
    logic             yumi_i, v_o, last_o;
    logic [W-1:0]     data_o;
    logic [1:0]       tag_o;

    logic [2:0]       v3, last3, ready3;
    logic [3*W-1:0]   data3;
    logic             yumi3, v3_o, last3_o;
    logic [W-1:0]     data3_o;
    logic [1:0]       tag3_o;

    always #5 clk = ~clk;

    bsg_one_fifo_rr_arb #(.els_p(N), .width_p(W)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .last_i(last_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
        .tag_o(tag_o), .last_o(last_o), .yumi_i(yumi_i)
    );

    bsg_one_fifo_rr_arb #(.els_p(3), .width_p(W)) dut3 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v3), .data_i(data3),
        .last_i(last3), .ready_o(ready3), .v_o(v3_o), .data_o(data3_o),
        .tag_o(tag3_o), .last_o(last3_o), .yumi_i(yumi3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: buffer contents, owner of an open packet (-1: none)
    // and the requester with highest priority next.
    bit           m_full;
    logic [W-1:0] m_data;
    int           m_tag;
    bit           m_last;
    int           m_ptr;
    int           m_lock;

    function automatic void model_reset();
        m_full = 0; m_data = '0; m_tag = 0; m_last = 0; m_ptr = 0; m_lock = -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        if (reset_i || m_full) return '0;
        if (m_lock >= 0) return v_i[m_lock] ? (N'(1) << m_lock) : '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (v_i[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    // Advance the model by the current inputs, then clock to posedge+1.
    task automatic model_tick();
        logic [N-1:0] r;
        r = exp_ready();
        if (r != '0) begin
            int g;
            g = 0;
            for (int k = 0; k < N; k++) if (r[k]) g = k;
            m_full = 1;
            m_data = data_i[g*W +: W];
            m_tag  = g;
            m_last = last_i[g];
            if (last_i[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % N;
            end else begin
                m_lock = g;
            end
        end else if (yumi_i && m_full) begin
            $display("beat out: tag=%0d data=%h last=%0d", tag_o, data_o, last_o);
            m_full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        v_i = '0; last_i = '0; data_i = '0; yumi_i = 1'b0;
        v3 = '0; last3 = '0; data3 = '0; yumi3 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset_i = 1'b1;
        v_i = '1; last_i = '1;
        #1;
        checks++;
        if ({ready_o, v_o, data_o} !== '0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b v=%b data=%h, expected all zero", ready_o, v_o, data_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: ready=%b expected 0001", ready_o);
        end
        data_i = '0;
        data_i[W-1:0] = 16'h1234;
        model_tick();
        checks++;
        if ({v_o, data_o, tag_o} !== {1'b1, 16'h1234, 2'd0}) begin
            errors++;
            $display("FAIL reset_load: v=%b data=%h tag=%0d expected 1 1234 0", v_o, data_o, tag_o);
        end
        #3;
        reset_i = 1'b1;
        #1;
        checks++;
        if ({ready_o, v_o, data_o, tag_o, last_o} !== '0) begin
            errors++;
            $display("FAIL reset_async: ready=%b v=%b data=%h tag=%0d last=%b expected all zero",
                     ready_o, v_o, data_o, tag_o, last_o);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL reset_regrant: ready=%b expected 0001", ready_o);
        end
    endtask

    task automatic test_fairness();
        int tags[$];
        int exp_tags[5] = '{0, 1, 2, 3, 0};
        do_reset();
        v_i = '1; last_i = '1;
        for (int c = 0; c < 10; c++) begin
            data_i = {$urandom, $urandom};
            yumi_i = m_full;
            #1;
            checks++;
            if (ready_o !== exp_ready()) begin
                errors++;
                $display("FAIL fair_ready: got %b expected %b", ready_o, exp_ready());
            end
            if (m_full && yumi_i) tags.push_back(int'(tag_o));
            model_tick();
        end
        yumi_i = 1'b0;
        checks++;
        if (tags.size() != 5) begin
            errors++;
            $display("FAIL fair_rate: beats=%0d expected 5 in 10 cycles", tags.size());
        end
        for (int i = 0; i < 5 && i < tags.size(); i++) begin
            checks++;
            if (tags[i] != exp_tags[i]) begin
                errors++;
                $display("FAIL fair_order[%0d]: tag=%0d expected %0d", i, tags[i], exp_tags[i]);
            end
        end
    endtask

    task automatic test_packet_lock();
        int tags[$];
        logic [W-1:0] datas[$];
        int beat2;
        int exp_tags[4] = '{2, 2, 2, 3};
        logic [W-1:0] exp_data[3] = '{16'hA001, 16'hA002, 16'hA003};
        do_reset();
        // Move the pointer to requester 2 with a single-beat packet from 1.
        v_i = 4'b0010; last_i = 4'b0010; data_i = {$urandom, $urandom};
        model_tick();
        yumi_i = 1'b1;
        model_tick();
        beat2 = 0;
        v_i = '1;
        for (int c = 0; c < 12 && tags.size() < 4; c++) begin
            logic [N-1:0] r;
            data_i = {$urandom, $urandom};
            data_i[2*W +: W] = 16'hA001 + 16'(beat2);
            last_i = 4'b1011 | ((beat2 == 2) ? 4'b0100 : 4'b0000);
            yumi_i = m_full;
            #1;
            r = exp_ready();
            checks++;
            if (ready_o !== r) begin
                errors++;
                $display("FAIL lock_ready: got %b expected %b", ready_o, r);
            end
            if (m_full && yumi_i) begin
                tags.push_back(int'(tag_o));
                datas.push_back(data_o);
            end
            if (r[2]) beat2++;
            model_tick();
        end
        yumi_i = 1'b0;
        checks++;
        if (tags.size() != 4) begin
            errors++;
            $display("FAIL lock_count: beats=%0d expected 4", tags.size());
        end
        for (int i = 0; i < tags.size(); i++) begin
            checks++;
            if (tags[i] != exp_tags[i] || (i < 3 && datas[i] !== exp_data[i])) begin
                errors++;
                $display("FAIL lock_beat[%0d]: tag=%0d data=%h expected tag %0d", i, tags[i], datas[i], exp_tags[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d0;
        do_reset();
        v_i = 4'b0011; last_i = 4'b0011;
        data_i = {$urandom, $urandom};
        d0 = data_i[W-1:0];
        model_tick();
        for (int c = 0; c < 10; c++) begin
            data_i = {$urandom, $urandom};
            #1;
            checks++;
            if (v_o !== 1'b1 || data_o !== d0 || ready_o !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: v=%b data=%h ready=%b expected 1 %h 0000", c, v_o, data_o, ready_o, d0);
            end
            model_tick();
        end
        yumi_i = 1'b1;
        model_tick();
        yumi_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release: ready=%b expected 0010", ready_o);
        end
        model_tick();
        checks++;
        if (v_o !== 1'b1 || tag_o !== 2'd1) begin
            errors++;
            $display("FAIL bp_next_tag: v=%b tag=%0d expected 1 1", v_o, tag_o);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        v_i = 4'b0010; last_i = 4'b0000; data_i = {$urandom, $urandom};
        model_tick();
        v_i = 4'b0101; yumi_i = 1'b1;
        model_tick();
        yumi_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL rmp_starve: ready=%b expected 0000", ready_o);
        end
        reset_i = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i = 4'b0011;
        #1;
        checks++;
        if (ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL rmp_regrant: ready=%b expected 0001", ready_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v_i = N'($urandom);
            last_i = N'($urandom);
            data_i = {$urandom, $urandom};
            yumi_i = m_full && ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (ready_o !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, ready_o, exp_ready());
            end
            checks++;
            if ({v_o, data_o, tag_o, last_o} !== {m_full, m_data, 2'(m_tag), m_last}) begin
                errors++;
                $display("FAIL rand_out[%0d]: v=%b data=%h tag=%0d last=%b expected %b %h %0d %b",
                         c, v_o, data_o, tag_o, last_o, m_full, m_data, m_tag, m_last);
            end
            model_tick();
        end
        yumi_i = 1'b0;
    endtask

    task automatic test_wrap3();
        int tags[$];
        int exp_tags[6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        v3 = '1; last3 = '1;
        for (int c = 0; c < 14; c++) begin
            data3 = 48'($urandom);
            yumi3 = v3_o;
            #1;
            checks++;
            if (dut3.ptr_r >= 2'd3) begin
                errors++;
                $display("FAIL wrap_ptr[%0d]: ptr=%0d expected < 3", c, dut3.ptr_r);
            end
            if (v3_o && yumi3) tags.push_back(int'(tag3_o));
            @(posedge clk);
            #1;
        end
        yumi3 = 1'b0;
        checks++;
        if (tags.size() < 6) begin
            errors++;
            $display("FAIL wrap_count: beats=%0d expected at least 6", tags.size());
        end
        for (int i = 0; i < 6 && i < tags.size(); i++) begin
            checks++;
            if (tags[i] != exp_tags[i]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: tag=%0d expected %0d", i, tags[i], exp_tags[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        v_i = '0; last_i = '0; data_i = '0; yumi_i = 1'b0;
        v3 = '0; last3 = '0; data3 = '0; yumi3 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        test_wrap3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
